// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared state type and default constants for dac_spi_tx.
// Optional power-down frame bits are enabled with DAC_SPI_PD_BITS_EN.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    IDLE  = 2'd1,
    SETUP = 2'd2,
    SHIFT = 2'd3
  } dac_state_e;

  localparam int DAC_FRAME_BITS = 16;
  localparam int DAC_DATA_WIDTH = 14;

  localparam logic [1:0] PD_NORMAL   = 2'b00;
  localparam logic [1:0] PD_1K_GND   = 2'b01;
  localparam logic [1:0] PD_100K_GND = 2'b10;
  localparam logic [1:0] PD_TRISTATE = 2'b11;

endpackage

// File: rtl/spi_half_bit_timer.sv
// spi_half_bit_timer: free-runs while EN is high and pulses TICK
// every CLKS_PER_HALF_BIT cycles; clears whenever EN drops.
module spi_half_bit_timer
  import dac_spi_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 8
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  localparam int CW = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_HALF_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (!EN || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign TICK = EN && (cnt == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: SPI master that serialises one DAC sample per handshake.
// Define DAC_SPI_PD_BITS_EN to add PD_MODE bits above the data.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 8,
  parameter int DATA_WIDTH        = DAC_DATA_WIDTH,
  parameter int FRAME_BITS        = DAC_FRAME_BITS,
  parameter int CS_IDLE_CLKS      = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  DV_IN,
`ifdef DAC_SPI_PD_BITS_EN
  input  logic [1:0]            PD_MODE,
`endif
  output logic                  READY,
  output logic                  SCLK,
  output logic                  MOSI,
  output logic                  CS,
  output logic                  DONE
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int GW = $clog2(CS_IDLE_CLKS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_IDLE_CLKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);

  localparam logic [1:0] S_GAP   = GAP;
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SETUP = SETUP;
  localparam logic [1:0] S_SHIFT = SHIFT;

  if (CLKS_PER_HALF_BIT < 2 || CS_IDLE_CLKS < 1 ||
      FRAME_BITS < DATA_WIDTH) begin : g_prm_chk
    $error("dac_spi_tx: illegal parameter set");
  end

`ifdef DAC_SPI_PD_BITS_EN
  if (FRAME_BITS - DATA_WIDTH < 2) begin : g_pd_chk
    $error("dac_spi_tx: PD bits need two pad bits");
  end
`endif

  logic [1:0]            state;
  logic [GW-1:0]         gap_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-2:0] sreg;
  logic [FRAME_BITS-1:0] frame;
  logic                  tick;
  logic                  timer_en;

  always_comb begin
    frame = '0;
    frame[DATA_WIDTH-1:0] = DATA_IN;
`ifdef DAC_SPI_PD_BITS_EN
    frame[DATA_WIDTH +: 2] = PD_MODE;
`endif
  end

  assign timer_en = (state == S_SETUP) || (state == S_SHIFT);

  spi_half_bit_timer #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_timer (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .EN   (timer_en),
    .TICK (tick)
  );

  // MOSI holds the current bit; sreg keeps only the bits still to send.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state   <= S_GAP;
      gap_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
      CS      <= 1'b1;
      SCLK    <= 1'b1;
      MOSI    <= 1'b0;
      READY   <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (1'b1)
        (state == S_GAP): begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            READY   <= 1'b1;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        (state == S_IDLE): begin
          if (DV_IN) begin
            sreg  <= frame[FRAME_BITS-2:0];
            MOSI  <= frame[FRAME_BITS-1];
            CS    <= 1'b0;
            READY <= 1'b0;
            state <= S_SETUP;
          end
        end
        (state == S_SETUP): begin
          if (tick) begin
            SCLK    <= 1'b0;
            bit_cnt <= BW'(1);
            state   <= S_SHIFT;
          end
        end
        (state == S_SHIFT): begin
          if (tick) begin
            if (!SCLK) begin
              SCLK <= 1'b1;
              MOSI <= sreg[FRAME_BITS-2];
              sreg <= sreg << 1;
            end else if (bit_cnt == BIT_LAST) begin
              CS      <= 1'b1;
              MOSI    <= 1'b0;
              DONE    <= 1'b1;
              bit_cnt <= '0;
              state   <= S_GAP;
            end else begin
              SCLK    <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= S_GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed bench with a closed-form timing model of
// the DAC SPI frame and a per-cycle output compare.
module tb_dac_spi_tx;
  import dac_spi_pkg::*;

  localparam int H  = 8;
  localparam int DW = 14;
  localparam int FB = 16;
  localparam int G  = 4;
  localparam int FRAME_CLKS = H * (1 + 2 * FB);

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          DV_IN = 1'b0;
  logic [DW-1:0] DATA_IN = '0;
`ifdef DAC_SPI_PD_BITS_EN
  logic [1:0]    PD_MODE = 2'b00;
`endif
  logic READY, SCLK, MOSI, CS, DONE;

  int checks = 0;
  int errors = 0;

  logic [FB-1:0] frames[$];
  int            lows[$];
  int            highs[$];
  int            done_cnt = 0;

  dac_spi_tx #(
    .CLKS_PER_HALF_BIT(H),
    .DATA_WIDTH       (DW),
    .FRAME_BITS       (FB),
    .CS_IDLE_CLKS     (G)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .DATA_IN(DATA_IN),
    .DV_IN  (DV_IN),
`ifdef DAC_SPI_PD_BITS_EN
    .PD_MODE(PD_MODE),
`endif
    .READY  (READY),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .CS     (CS),
    .DONE   (DONE)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Model: outputs are a pure function of edges since the accepting edge.
  initial begin : compare
    int n, acc, rdy_edge, k, h, idx, lo, hi, nb, shown;
    bit act, hi_ok, e_ready, dv, rst, s, m;
    bit p_sclk, p_mosi, p_cs;
    logic [DW-1:0] din;
    logic [1:0] pd;
    logic [FB-1:0] mf, asmb;
    logic [4:0] exp, got;
    n = 0; acc = 0; rdy_edge = G; lo = 0; hi = 0; nb = 0; shown = 0;
    act = 0; hi_ok = 0; e_ready = 0;
    p_sclk = 1; p_mosi = 0; p_cs = 1;
    mf = '0; asmb = '0; pd = 2'b00;
    forever begin
      @(posedge CLOCK);
      rst = RESET;
      dv  = DV_IN;
      din = DATA_IN;
`ifdef DAC_SPI_PD_BITS_EN
      pd = PD_MODE;
`endif
      #1;
      if (rst) begin
        n = 0; act = 0; rdy_edge = G; e_ready = 0;
        exp = 5'b11000;
        nb = 0; lo = 0; hi_ok = 0;
      end else begin
        n++;
        if (!act && e_ready && dv) begin
          act = 1;
          acc = n;
          mf = FB'(din);
          mf[DW +: 2] = pd;
        end
        if (act) begin
          k = n - acc;
          e_ready = 0;
          if (k < FRAME_CLKS) begin
            if (k < H) begin
              s = 1;
              idx = FB - 1;
            end else begin
              h = (k - H) / H;
              s = (h % 2) == 1;
              idx = FB - 1 - (h + 1) / 2;
            end
            m = (idx >= 0) ? mf[idx] : 1'b0;
            exp = {1'b0, s, m, 2'b00};
          end else begin
            exp = 5'b11001;
            act = 0;
            rdy_edge = n + G;
          end
        end else begin
          e_ready = (n >= rdy_edge);
          exp = {3'b110, e_ready, 1'b0};
        end
      end
      got = {CS, SCLK, MOSI, READY, DONE};
      checks++;
      if (got !== exp) begin
        errors++;
        if (shown < 30) begin
          shown++;
          $display("FAIL cycle_outputs t=%0t {CS,SCLK,MOSI,READY,DONE} got %b want %b",
                   $time, got, exp);
        end
      end
      if (!rst) begin
        if (p_sclk && !SCLK) begin
          checks++;
          if (MOSI !== p_mosi) begin
            errors++;
            $display("FAIL mosi_stable t=%0t got %b want %b", $time, MOSI, p_mosi);
          end
          asmb = {asmb[FB-2:0], MOSI};
          nb++;
        end
        if (!CS) begin
          if (p_cs && hi_ok) highs.push_back(hi);
          lo++;
        end else if (!p_cs) begin
          if (nb == FB) frames.push_back(asmb);
          lows.push_back(lo);
          lo = 0; nb = 0; hi_ok = 1; hi = 1;
        end else begin
          hi++;
        end
        if (DONE) done_cnt++;
      end
      p_sclk = SCLK;
      p_mosi = MOSI;
      p_cs   = CS;
    end
  end

  task automatic ready_rise(output int j);
    j = 0;
    while (j < 50) begin
      @(posedge CLOCK);
      #1;
      j++;
      if (READY) break;
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    int c;
    c = 0;
    @(negedge CLOCK);
    while (READY !== 1'b1 && c < 400) begin
      @(negedge CLOCK);
      c++;
    end
    check("ready_wait", int'(c < 400), 1);
    DATA_IN = d;
    DV_IN = 1'b1;
    @(negedge CLOCK);
    DV_IN = 1'b0;
  endtask

  task automatic wait_done(output int j);
    j = 1;
    while (j < 600) begin
      @(posedge CLOCK);
      #1;
      j++;
      if (DONE) break;
    end
    check("done_seen", int'(DONE), 1);
  endtask

  initial begin : stim
    int j, nf, nl, f, dc, c;
    bit p;
    repeat (3) @(negedge CLOCK);
    check("reset_outs", int'({CS, SCLK, MOSI, READY, DONE}), 'b11000);
    RESET = 1'b0;
    ready_rise(j);
    check("ready_first_cycle", j + 1, G + 1);

    send(14'h2AAA);
    wait_done(j);
    check("accept_to_done", j, 265);
    check("frame_2aaa", int'(frames[$]), 'h2AAA);
    check("cs_low_len", lows[$], 264);
    check("done_count", done_cnt, 1);

    @(negedge CLOCK);
    c = 0;
    while (READY !== 1'b1 && c < 400) begin
      @(negedge CLOCK);
      c++;
    end
    DATA_IN = 14'h3FFF;
    DV_IN = 1'b1;
    @(negedge CLOCK);
    DATA_IN = 14'h0000;
    wait_done(j);
    c = 0;
    do begin
      @(negedge CLOCK);
      c++;
    end while (CS && c < 20);
    check("b2b_restart", int'(c < 20), 1);
    DV_IN = 1'b0;
    wait_done(j);
    check("b2b_frame_cnt", frames.size(), 3);
    check("frame_3fff", int'(frames[1]), 'h3FFF);
    check("frame_0000", int'(frames[2]), 'h0000);
    check("cs_gap_len", highs[$], G + 1);

    send(14'h0F0F);
    repeat (98) @(negedge CLOCK);
    DATA_IN = 14'h1234;
    DV_IN = 1'b1;
    @(negedge CLOCK);
    DV_IN = 1'b0;
    wait_done(j);
    nf = frames.size();
    nl = lows.size();
    repeat (300) @(negedge CLOCK);
    check("frame_0f0f", int'(frames[$]), 'h0F0F);
    check("no_extra_frame", frames.size(), nf);
    check("no_extra_cs", lows.size(), nl);
    check("ready_after_drop", int'(READY), 1);

    send(14'h3C3C);
    f = 0;
    p = 1;
    c = 0;
    while (f < 7 && c < 400) begin
      @(posedge CLOCK);
      #1;
      if (p && !SCLK) f++;
      p = SCLK;
      c++;
    end
    check("seventh_fall", f, 7);
    nf = frames.size();
    dc = done_cnt;
    #1;
    RESET = 1'b1;
    #1;
    check("async_reset_outs", int'({CS, SCLK, MOSI, DONE}), 'b1100);
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    ready_rise(j);
    check("ready_after_reset", j + 1, G + 1);
    check("no_done_on_abort", done_cnt, dc);
    check("no_partial_frame", frames.size(), nf);
    send(14'h0155);
    wait_done(j);
    check("frame_0155", int'(frames[$]), 'h0155);

`ifdef DAC_SPI_PD_BITS_EN
    PD_MODE = 2'b11;
    send(14'h0000);
    wait_done(j);
    check("frame_pd11", int'(frames[$]), 'hC000);
    PD_MODE = 2'b00;
    send(14'h0000);
    wait_done(j);
    check("frame_pd00", int'(frames[$]), 'h0000);
`endif

    repeat (20) @(negedge CLOCK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
SPI master transmitter driving a 14-bit serial DAC (16-bit frame: 2 pad/control bits + 14 data bits, MSB first). Write-side counterpart of the ADC SPI reader.
- Uses the same SCLK timing (CLKS_PER_HALF_BIT) and SCLK idle-high polarity as the ADC reader.
- Sits between the FFT/DSP output path and the DAC pins.
- Accepts one sample per valid/ready handshake and serialises it; no buffering beyond the shift register.

Parameters:
CLKS_PER_HALF_BIT, 8, CLOCK cycles per SCLK half period (>=2)
DATA_WIDTH, 14, sample width
FRAME_BITS, 16, bits per CS-low frame (>= DATA_WIDTH; upper FRAME_BITS-DATA_WIDTH bits are pad)
CS_IDLE_CLKS, 4, minimum CLOCK cycles CS held high between frames (>=1)

Ports:
CLOCK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
DATA_IN  in  DATA_WIDTH  sample to send
DV_IN  in  1  sample valid
READY  out  1  block can accept a sample
SCLK  out  1  SPI clock, idle high
MOSI  out  1  serial data to DAC
CS  out  1  chip select, active low
DONE  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset is asynchronous, active-high.
- Reset values: CS=1, SCLK=1, MOSI=0, READY=0, DONE=0. State=GAP, gap counter=0.
- All outputs are registered.
- States: GAP -> IDLE -> SETUP -> SHIFT -> GAP.
- GAP:
  - CS=1, SCLK=1, READY=0.
  - Counts CS_IDLE_CLKS cycles, then goes to IDLE.
  - Because reset enters GAP, CS minimum high time is guaranteed after an aborted frame. READY first rises CS_IDLE_CLKS+1 cycles after RESET deasserts.
- IDLE:
  - READY=1.
  - Accept occurs on a rising edge with DV_IN=1 and READY=1.
  - On accept: shift register <= {pad, DATA_IN}, pad=0. Next cycle: READY=0, CS=0, MOSI=frame bit FRAME_BITS-1. Go to SETUP.
  - DV_IN while READY=0 is ignored; the sample is dropped and no error is raised.
- SETUP:
  - SCLK stays high for CLKS_PER_HALF_BIT cycles (MOSI setup before first falling edge), then go to SHIFT.
- SHIFT:
  - Each bit is two half periods: SCLK low for CLKS_PER_HALF_BIT cycles, then high for CLKS_PER_HALF_BIT cycles. The DAC samples on the SCLK falling edge.
  - MOSI changes only in the same cycle SCLK rises, to the next lower bit. It is held through the low phase.
  - After the high phase of bit 0 (the FRAME_BITS-th bit), in one cycle: CS=1, MOSI=0, DONE=1 for exactly that cycle, state=GAP.
- Timing, defaults:
  - CS low for CLKS_PER_HALF_BIT*(1+2*FRAME_BITS) = 264 cycles.
  - Accept-to-DONE latency = 265 cycles.
  - Accept-to-next-READY = 265+CS_IDLE_CLKS = 269 cycles.
- SCLK pulse count per frame is exactly FRAME_BITS falling edges. SCLK is never low while CS=1.
- Half-bit counter width: $clog2(CLKS_PER_HALF_BIT). Bit counter width: $clog2(FRAME_BITS+1). Neither wraps mid-frame.
- RESET mid-frame: CS, SCLK, MOSI take their reset values immediately (asynchronous), the frame is aborted and the shift data is discarded.
- DV_IN held high continuously yields back-to-back frames, each separated by CS_IDLE_CLKS+1 cycles of CS high.

Optional Feature:
Macro DAC_SPI_PD_BITS_EN.
- When defined:
  - Adds input PD_MODE[1:0], latched together with DATA_IN at accept.
  - The two frame bits directly above the data are PD_MODE; any remaining pad bits are 0.
  - Requires FRAME_BITS-DATA_WIDTH >= 2 (elaboration-time check).
- When undefined: port absent; all pad bits are 0.

Decomposition:
- Package dac_spi_pkg:
  - state enum (GAP, IDLE, SETUP, SHIFT)
  - default constants DAC_FRAME_BITS=16, DAC_DATA_WIDTH=14, PD mode encodings (00 normal, 01 1k-to-GND, 10 100k-to-GND, 11 tri-state)
- Sub-module spi_half_bit_timer, parameterised by CLKS_PER_HALF_BIT:
  - runs while enabled and emits a tick every CLKS_PER_HALF_BIT cycles
  - reusable later by the ADC reader

Test Plan:
1. Reset release -> CS=1, SCLK=1, READY=0 held for CS_IDLE_CLKS cycles; READY=1 at cycle CS_IDLE_CLKS+1.
2. DATA_IN=14'h2AAA with DV_IN pulse -> bits sampled on the 16 SCLK falling edges = 0010_1010_1010_1010; CS low for 264 cycles; DONE pulses once at cycle 265.
3. DATA_IN=14'h3FFF, then 14'h0000 with DV_IN held high -> two frames (16'h3FFF, 16'h0000); CS high for exactly 5 cycles between them; MOSI stable across every falling edge.
4. DV_IN pulse with DATA_IN=14'h1234 at cycle 100 of a frame in progress -> ignored; the current frame completes unchanged and no second frame starts.
5. RESET asserted at the 7th falling edge -> CS=1, SCLK=1 the same cycle; no DONE pulse; READY returns after the gap; the next frame 14'h0155 transmits correctly.
6. With DAC_SPI_PD_BITS_EN, PD_MODE=2'b11, DATA_IN=0 -> frame 16'hC000; with PD_MODE=2'b00 -> 16'h0000.
